// File: rtl/ibuf_multi_if.sv
// ibuf_multi_if: fetch push lanes and decode pop lanes of the multi-lane instruction buffer
interface ibuf_multi_if #(
    parameter int PUSH_W = 2,
    parameter int POP_W  = 2
);
    localparam int PRW = $clog2(POP_W + 1);
    logic [PUSH_W-1:0]    push_valid;
    logic [32*PUSH_W-1:0] push_instr;
    logic [32*PUSH_W-1:0] push_pc;
    logic [PUSH_W-1:0]    push_addr_err;
    logic                 push_ready;
    logic [PRW-1:0]       pop_req;
    logic [PRW-1:0]       pop_avail;
    logic [POP_W-1:0]     pop_valid;
    logic [32*POP_W-1:0]  pop_instr;
    logic [32*POP_W-1:0]  pop_pc;
    logic [POP_W-1:0]     pop_addr_err;
    modport master (
        output push_valid, push_instr, push_pc, push_addr_err, pop_req,
        input  push_ready, pop_avail, pop_valid, pop_instr, pop_pc, pop_addr_err
    );
    modport slave (
        input  push_valid, push_instr, push_pc, push_addr_err, pop_req,
        output push_ready, pop_avail, pop_valid, pop_instr, pop_pc, pop_addr_err
    );
endinterface

// File: rtl/ibuf_multi.sv
// ibuf_multi: multi-lane fetch-to-decode instruction buffer; define IBUF_BYPASS_EN for empty-buffer bypass
module ibuf_multi #(
    parameter int DEPTH  = 8,
    parameter int PUSH_W = 2,
    parameter int POP_W  = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    ibuf_multi_if.slave                bus,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int PRW = $clog2(POP_W + 1);
    localparam int MW  = PUSH_W > POP_W ? PUSH_W : POP_W;
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        err;
    } entry_t;
    entry_t        mem_q [DEPTH];
    entry_t        mem_d [DEPTH];
    entry_t        lane_in [MW];
    entry_t        lane_out;
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          run, byp;
    int            nlead, npush, npop, avail;
`ifdef IBUF_BYPASS_EN
    assign byp = count_q == '0 && !flush;
`else
    assign byp = 1'b0;
`endif
    assign count          = count_q;
    assign bus.push_ready = count_q <= CW'(DEPTH - PUSH_W);
    assign bus.pop_avail  = PRW'(avail);
    // lanes after the first clear valid bit are dropped
    always_comb begin
        run   = 1'b1;
        nlead = 0;
        for (int i = 0; i < MW; i++) lane_in[i] = entry_t'(0);
        for (int i = 0; i < PUSH_W; i++) begin
            run        = run & bus.push_valid[i];
            nlead      = nlead + (run ? 1 : 0);
            lane_in[i] = {bus.push_instr[32*i +: 32], bus.push_pc[32*i +: 32], bus.push_addr_err[i]};
        end
        npush = bus.push_ready ? nlead : 0;
        avail = byp ? npush : int'(count_q);
        avail = avail < POP_W ? avail : POP_W;
        npop  = int'(bus.pop_req) < avail ? int'(bus.pop_req) : avail;
    end
    always_comb begin
        bus.pop_valid    = '0;
        bus.pop_instr    = '0;
        bus.pop_pc       = '0;
        bus.pop_addr_err = '0;
        lane_out         = entry_t'(0);
        for (int i = 0; i < POP_W; i++) begin
            lane_out                 = i >= avail ? entry_t'(0) : byp ? lane_in[i] : mem_q[rptr_q + AW'(i)];
            bus.pop_valid[i]         = i < avail;
            bus.pop_instr[32*i +: 32] = lane_out.instr;
            bus.pop_pc[32*i +: 32]    = lane_out.pc;
            bus.pop_addr_err[i]       = lane_out.err;
        end
    end
    // bypassed lanes consumed this cycle are never stored; rptr skips over their slots
    always_comb begin
        mem_d = mem_q;
        for (int i = 0; i < PUSH_W; i++)
            if (i < npush && !(byp && i < npop)) mem_d[wptr_q + AW'(i)] = lane_in[i];
        wptr_d  = flush ? '0 : wptr_q + AW'(npush);
        rptr_d  = flush ? '0 : rptr_q + AW'(npop);
        count_d = flush ? '0 : count_q + CW'(npush) - CW'(npop);
    end
    always_ff @(posedge clk) begin
        wptr_q  <= rst ? '0 : wptr_d;
        rptr_q  <= rst ? '0 : rptr_d;
        count_q <= rst ? '0 : count_d;
        mem_q   <= mem_d;
    end
endmodule
